// File: rtl/sensor_persistence_filter.sv
// sensor_persistence_filter
//   Filters per-round sensor response vectors from the multi-sensor response
//   checker. Each channel keeps a saturating consecutive-miss counter. A sticky
//   fault bit is latched once the miss count reaches a programmable threshold.
//   A watchdog flags the round stream as stale when rounds stop arriving.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   round_valid  : one-cycle strobe, round_resp holds a round result
//   round_resp   : per-sensor response bits (1 = responded in time)
//   active_mask  : per-sensor monitor enable
//   threshold    : consecutive-miss count that sets a fault (0 = never set)
//   timeout      : max cycles between rounds (0 = watchdog disabled)
//   fault_clr    : write-1-to-clear strobe for fault bits
//   miss_cnt     : packed miss counters, channel i at [i*CNT_W +: CNT_W]
//   fault        : sticky per-sensor fault flags
//   fault_rise   : one-cycle pulse when any fault bit rises
//   stale        : watchdog expired
//   round_count  : accepted rounds, wraps at 16 bits
//   irq          : |fault OR stale
module sensor_persistence_filter #(
    parameter int unsigned N_SENSORS = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         round_valid,
    input  logic [N_SENSORS-1:0]         round_resp,
    input  logic [N_SENSORS-1:0]         active_mask,
    input  logic [CNT_W-1:0]             threshold,
    input  logic [TIMEOUT_W-1:0]         timeout,
    input  logic [N_SENSORS-1:0]         fault_clr,
    output logic [N_SENSORS*CNT_W-1:0]   miss_cnt,
    output logic [N_SENSORS-1:0]         fault,
    output logic                         fault_rise,
    output logic                         stale,
    output logic [15:0]                  round_count,
    output logic                         irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALE = 2'd2
    } wd_state_t;

    wd_state_t                   state_q, state_d;
    logic [TIMEOUT_W-1:0]        wd_q, wd_d;
    logic [TIMEOUT_W-1:0]        timeout_m1;

    logic [N_SENSORS*CNT_W-1:0]  cnt_d;
    logic [N_SENSORS-1:0]        set_vec;
    logic [N_SENSORS-1:0]        fault_d;
    logic [CNT_W-1:0]            cur;
    logic [CNT_W:0]              inc;

    // Per-channel counter update and fault-set detection. The set compare
    // uses the unsaturated count+1 so a saturated counter still qualifies.
    always_comb begin
        cnt_d   = miss_cnt;
        set_vec = '0;
        cur     = '0;
        inc     = '0;
        if (round_valid) begin
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                cur = miss_cnt[i*CNT_W +: CNT_W];
                inc = {1'b0, cur} + {{CNT_W{1'b0}}, 1'b1};
                if (active_mask[i] && !round_resp[i]) begin
                    cnt_d[i*CNT_W +: CNT_W] = (cur == '1) ? cur : inc[CNT_W-1:0];
                    if ((threshold != '0) && (inc >= {1'b0, threshold}))
                        set_vec[i] = 1'b1;
                end else begin
                    cnt_d[i*CNT_W +: CNT_W] = '0;
                end
            end
        end
    end

    // Set has priority over clear.
    assign fault_d = (fault & ~fault_clr) | set_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt    <= '0;
            fault       <= '0;
            fault_rise  <= 1'b0;
            round_count <= '0;
        end else begin
            miss_cnt   <= cnt_d;
            fault      <= fault_d;
            fault_rise <= |(fault_d & ~fault);
            if (round_valid)
                round_count <= round_count + 16'd1;
        end
    end

    // Watchdog
    assign timeout_m1 = timeout - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        if (timeout == '0) begin
            state_d = S_IDLE;
            wd_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wd_d = '0;
                    if (round_valid)
                        state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (round_valid) begin
                        wd_d = '0;
                    end else if (wd_q == timeout_m1) begin
                        state_d = S_STALE;
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_STALE: begin
                    wd_d = '0;
                    if (round_valid)
                        state_d = S_WAIT;
                end
                default: begin
                    state_d = S_IDLE;
                    wd_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    assign stale = (state_q == S_STALE);
    assign irq   = (|fault) | stale;

endmodule

// File: tb/tb_sensor_persistence_filter.sv
// Directed testbench for sensor_persistence_filter.
module tb_sensor_persistence_filter;

    localparam int unsigned N = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            round_valid;
    logic [N-1:0]    round_resp;
    logic [N-1:0]    active_mask;
    logic [CW-1:0]   threshold;
    logic [TW-1:0]   timeout;
    logic [N-1:0]    fault_clr;
    logic [N*CW-1:0] miss_cnt;
    logic [N-1:0]    fault;
    logic            fault_rise;
    logic            stale;
    logic [15:0]     round_count;
    logic            irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_persistence_filter #(
        .N_SENSORS(N),
        .CNT_W(CW),
        .TIMEOUT_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .round_valid(round_valid),
        .round_resp(round_resp),
        .active_mask(active_mask),
        .threshold(threshold),
        .timeout(timeout),
        .fault_clr(fault_clr),
        .miss_cnt(miss_cnt),
        .fault(fault),
        .fault_rise(fault_rise),
        .stale(stale),
        .round_count(round_count),
        .irq(irq)
    );

    // Inputs change on negedge; outputs sampled on negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; round_valid = 1'b0; round_resp = '0; active_mask = 8'hFF;
        threshold = '0; timeout = '0; fault_clr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_round(input logic [N-1:0] resp, input logic [N-1:0] clr);
        @(negedge clk);
        round_valid = 1'b1; round_resp = resp; fault_clr = clr;
        @(negedge clk);
        round_valid = 1'b0; fault_clr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({miss_cnt, fault, fault_rise, stale, round_count, irq} !== '0) begin
            errors++;
            $display("FAIL reset: miss_cnt=%h fault=%h rise=%b stale=%b rc=%h irq=%b (want all 0)",
                     miss_cnt, fault, fault_rise, stale, round_count, irq);
        end
    endtask

    task automatic test_threshold_clear();
        logic [CW-1:0] exp_c [3];
        exp_c[0] = 4'd1; exp_c[1] = 4'd2; exp_c[2] = 4'd3;
        do_reset();
        threshold = 4'd3;
        for (int r = 0; r < 3; r++) begin
            do_round(8'hFE, 8'h00);
            checks++;
            if (miss_cnt !== {28'h0, exp_c[r]}) begin
                errors++;
                $display("FAIL thr_cnt r%0d: got %h want %h", r, miss_cnt, {28'h0, exp_c[r]});
            end
            checks++;
            if (fault !== ((r == 2) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL thr_fault r%0d: got %h", r, fault);
            end
            checks++;
            if (fault_rise !== (r == 2)) begin
                errors++;
                $display("FAIL thr_rise r%0d: got %b want %b", r, fault_rise, (r == 2));
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL thr_irq: got %b want 1", irq);
        end
        @(negedge clk);
        checks++;
        if (fault_rise !== 1'b0) begin
            errors++; $display("FAIL thr_rise_pulse: got %b want 0", fault_rise);
        end
        fault_clr = 8'h01;
        @(negedge clk);
        fault_clr = 8'h00;
        checks++;
        if ({fault, irq} !== 9'h0) begin
            errors++; $display("FAIL clr: fault=%h irq=%b want 0", fault, irq);
        end
        checks++;
        if (miss_cnt !== 32'h3) begin
            errors++; $display("FAIL clr_cnt: got %h want 00000003", miss_cnt);
        end
    endtask

    task automatic test_recovery();
        logic [N-1:0]  resp [4];
        logic [CW-1:0] exp_c [4];
        resp[0] = 8'hFE; resp[1] = 8'hFE; resp[2] = 8'hFF; resp[3] = 8'hFE;
        exp_c[0] = 4'd1; exp_c[1] = 4'd2; exp_c[2] = 4'd0; exp_c[3] = 4'd1;
        do_reset();
        threshold = 4'd3;
        for (int r = 0; r < 4; r++) begin
            do_round(resp[r], 8'h00);
            checks++;
            if (miss_cnt !== {28'h0, exp_c[r]} || fault !== 8'h00) begin
                errors++;
                $display("FAIL recovery r%0d: cnt=%h fault=%h want cnt=%h fault=00",
                         r, miss_cnt, fault, {28'h0, exp_c[r]});
            end
        end
    endtask

    task automatic test_saturation_mask();
        do_reset();
        threshold = 4'd0;
        for (int r = 0; r < 20; r++) do_round(8'h00, 8'h00);
        checks++;
        if (miss_cnt !== 32'hFFFF_FFFF || fault !== 8'h00) begin
            errors++;
            $display("FAIL saturate: cnt=%h fault=%h want FFFFFFFF/00", miss_cnt, fault);
        end
        active_mask = 8'h0F;
        do_round(8'h00, 8'h00);
        checks++;
        if (miss_cnt !== 32'h0000_FFFF || fault !== 8'h00) begin
            errors++;
            $display("FAIL mask: cnt=%h fault=%h want 0000FFFF/00", miss_cnt, fault);
        end
        active_mask = 8'hFF;
    endtask

    task automatic test_set_clear_race();
        do_reset();
        threshold = 4'd1;
        do_round(8'hFD, 8'h00);
        checks++;
        if (fault !== 8'h02 || fault_rise !== 1'b1) begin
            errors++; $display("FAIL race_pre: fault=%h rise=%b want 02/1", fault, fault_rise);
        end
        do_round(8'hFD, 8'h02);
        checks++;
        if (fault !== 8'h02 || fault_rise !== 1'b0) begin
            errors++; $display("FAIL race_setwins: fault=%h rise=%b want 02/0", fault, fault_rise);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        timeout = 16'd10;
        do_round(8'hFF, 8'h00);          // now just after edge 0
        repeat (9) @(negedge clk);       // after edge 9
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL wd_early: stale=%b want 0", stale);
        end
        @(negedge clk);                  // after edge 10
        checks++;
        if (stale !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL wd_expire: stale=%b irq=%b want 1/1", stale, irq);
        end
        repeat (4) @(negedge clk);       // after edge 14
        round_valid = 1'b1;
        @(negedge clk);                  // after edge 15
        round_valid = 1'b0;
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL wd_recover: stale=%b want 0", stale);
        end
        repeat (9) @(negedge clk);       // after edge 24
        round_valid = 1'b1;              // sampled on expiry edge 25
        @(negedge clk);
        round_valid = 1'b0;
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL wd_race: stale=%b want 0", stale);
        end
        repeat (9) @(negedge clk);       // after edge 34
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL wd_race_hold: stale=%b want 0", stale);
        end
        @(negedge clk);                  // after edge 35
        checks++;
        if (stale !== 1'b1) begin
            errors++; $display("FAIL wd_reexpire: stale=%b want 1", stale);
        end
        timeout = 16'd0;
        @(negedge clk);
        checks++;
        if (stale !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL wd_disable: stale=%b irq=%b want 0/0", stale, irq);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        @(negedge clk);
        round_valid = 1'b1; round_resp = 8'hFF;
        repeat (65537) @(negedge clk);
        round_valid = 1'b0;
        checks++;
        if (round_count !== 16'h0001) begin
            errors++; $display("FAIL wrap: round_count=%h want 0001", round_count);
        end
        threshold = 4'd1;
        do_round(8'hFE, 8'h00);
        checks++;
        if (fault !== 8'h01 || round_count !== 16'h0002 || miss_cnt !== 32'h1) begin
            errors++;
            $display("FAIL pre_rst: fault=%h rc=%h cnt=%h want 01/0002/00000001",
                     fault, round_count, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b1; round_valid = 1'b1; round_resp = 8'h00;
        @(negedge clk);
        rst = 1'b0; round_valid = 1'b0;
        checks++;
        if ({miss_cnt, fault, fault_rise, stale, round_count, irq} !== '0) begin
            errors++;
            $display("FAIL rst_round: miss_cnt=%h fault=%h rise=%b stale=%b rc=%h irq=%b (want all 0)",
                     miss_cnt, fault, fault_rise, stale, round_count, irq);
        end
    endtask

    initial begin
        rst = 1'b1; round_valid = 1'b0; round_resp = '0; active_mask = 8'hFF;
        threshold = '0; timeout = '0; fault_clr = '0;
        test_reset();
        test_threshold_clear();
        test_recovery();
        test_saturation_mask();
        test_set_clear_race();
        test_watchdog();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_persistence_filter.md
Name: sensor_persistence_filter

Overview:
- Sits directly downstream of the multi-sensor response checker.
- Consumes one response vector per measurement round: bit i = 1 means sensor i echoed within the time limit.
- Tracks consecutive misses per sensor with saturating counters and latches sticky per-sensor faults once a programmable threshold is reached.
- Raises an interrupt for faults, and flags the round stream as stale when the checker stops delivering rounds.

Parameters:
- N_SENSORS, 8: number of sensor channels.
- CNT_W, 4: width of each per-sensor miss counter.
- TIMEOUT_W, 16: width of the round watchdog counter.

Ports:
- clk  input  1  system clock (64 MHz nominal).
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- round_valid  input  1  one-cycle strobe: a round result is present on round_resp.
- round_resp  input  N_SENSORS  per-sensor response bits (1 = responded in time).
- active_mask  input  N_SENSORS  1 = channel monitored.
- threshold  input  CNT_W  consecutive-miss count that sets a fault; 0 disables fault setting.
- timeout  input  TIMEOUT_W  max cycles between round_valid strobes; 0 disables the watchdog.
- fault_clr  input  N_SENSORS  write-1-to-clear strobe for fault bits.
- miss_cnt  output  N_SENSORS*CNT_W  packed counters; channel i is at [i*CNT_W +: CNT_W].
- fault  output  N_SENSORS  sticky fault flags.
- fault_rise  output  1  one-cycle pulse when any fault bit goes 0 to 1.
- stale  output  1  watchdog expired; no round seen within timeout.
- round_count  output  16  number of accepted rounds, wraps.
- irq  output  1  equals |fault OR stale.

Behaviour:
- Reset: miss_cnt=0, fault=0, fault_rise=0, stale=0, round_count=0, irq=0, watchdog counter=0, FSM=IDLE.
- All state is registered. The results of a round are visible on the cycle after the round_valid cycle.

Per-channel update (only on a round_valid cycle):
- Active channel, resp=1: counter <= 0.
- Active channel, resp=0: counter <= counter+1, saturating at 2^CNT_W-1 with no wrap.
- Inactive channel: counter <= 0. Its fault bit is held, not set.
- Set condition: threshold!=0 AND active AND resp=0 AND (counter+1) >= threshold, evaluated on the pre-saturation value compared against the saturated limit.
- Set condition true: fault[i] <= 1.
- Threshold changed mid-stream: the new value applies on the next round. Existing counters are not reset.

Fault bits:
- fault_clr[i]=1 clears fault[i] on the next cycle.
- Set and clear on the same cycle: set wins.
- fault_clr has no effect on counters.
- fault_rise=1 for exactly one cycle when (new fault & ~old fault) != 0.

Round counting:
- round_count increments by 1 per round_valid and wraps 0xFFFF -> 0x0000.

Watchdog FSM, states IDLE, WAIT, STALE:
- IDLE: entered from reset or whenever timeout==0. stale=0. Goes to WAIT on the first round_valid with timeout!=0.
- WAIT: watchdog counter increments each cycle and is reset to 0 on round_valid. When counter == timeout-1 with no round_valid, go to STALE; stale=1 from the next cycle.
- STALE: stale=1. round_valid returns to WAIT with counter=0 and stale=0 on the next cycle; that round is processed normally.
- timeout becomes 0 in any state: go to IDLE next cycle, stale=0.
- round_valid on the same cycle as expiry: round_valid wins; stay in WAIT.

Other rules:
- irq is combinational OR of the registered fault and stale flags.
- Reset mid-round: everything returns to reset values and an in-flight round_valid is discarded. Reset has priority over all inputs.

Test Plan:
- Threshold and clear: threshold=3, active_mask=0xFF, round_resp=0xFE for 3 rounds -> miss_cnt[0] goes 1,2,3; fault=0x01 after round 3; one-cycle fault_rise; irq=1. Then fault_clr=0x01 -> fault=0, irq=0, miss_cnt[0] stays 3.
- Recovery: threshold=3; rounds 0xFE, 0xFE, 0xFF, 0xFE -> counter goes 1,2,0,1; fault stays 0.
- Saturation, masking, disable: threshold=0, round_resp=0x00, 20 rounds -> all counters = 15 (saturated), fault=0. Then active_mask=0x0F, one round -> counters 4-7 = 0, counters 0-3 remain 15.
- Set vs clear race: threshold=1, round_resp=0xFD with fault_clr=0x02 on the same cycle -> fault[1]=1 (set wins).
- Watchdog: timeout=10; one round, then idle -> stale=1 exactly 10 cycles after the round_valid cycle. A round arriving at cycle 15 -> stale=0 on the next cycle. A round on the expiry cycle -> stale stays 0.
- Wrap and reset: 65537 rounds -> round_count=1. Assert rst in the same cycle as a round_valid -> all outputs 0 on the next cycle.
